pc_predict_bht: RTL and testbench

Parametrised fetch-stage PC predictor for the Y86-64 pipeline, replacing the static always-taken predictor. Conditional jumps use a direct-mapped table of 2-bit saturating counters indexed by fetch PC and trained from the execute stage. An optional return-address stack predicts `ret` targets. `predPC` feeds the F-register PC select, and `f_pred_taken` travels with the instruction so that execute can detect mispredictions.

---
 rtl/pc_predict_bht.sv | 125 ++++++++++++
 tb/tb_pc_predict_bht.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_predict_bht.sv
// pc_predict_bht: fetch-stage next-PC predictor.
// Conditional jumps consult a direct-mapped table of 2-bit saturating
// counters indexed by the low PC bits and trained from execute.
// Define PC_PREDICT_RAS_EN to build the return-address stack for ret;
// without it ret falls through to f_valP and the pipeline's ret stall
// supplies the real target.
module pc_predict_bht #(
  parameter int IDX_BITS  = 4,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_stall,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [63:0] f_pc,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        e_upd,
  input  logic [63:0] e_pc,
  input  logic        e_Cnd,
  output logic [63:0] predPC,
  output logic        f_pred_taken
);

  localparam int NENT = 1 << IDX_BITS;

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  // Untagged: PCs that share low bits share a counter.
  logic [1:0] bht [NENT];
  logic [1:0] ctr;

  assign ctr = bht[f_pc[IDX_BITS-1:0]];

  for (genvar i = 0; i < NENT; i++) begin : g_bht
    // Per-entry counter: up on taken, down on not-taken, both saturating.
    // Resets to weakly taken so a cold table behaves like always-taken.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bht[i] <= 2'b10;
      end else if (e_upd && (e_pc[IDX_BITS-1:0] == IDX_BITS'(i))) begin
        if (e_Cnd && (bht[i] != 2'b11))
          bht[i] <= bht[i] + 2'b01;
        else if (!e_Cnd && (bht[i] != 2'b00))
          bht[i] <= bht[i] - 2'b01;
      end
    end
  end

`ifdef PC_PREDICT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  // tos points at the current top entry; cnt is occupancy, saturating at
  // RAS_DEPTH. Once full, a push wraps over the oldest entry.
  logic [63:0]   ras [RAS_DEPTH];
  logic [PW-1:0] tos;
  logic [PW-1:0] tos_nxt;
  logic [PW:0]   cnt;
  logic          ras_hit;
  logic          do_push;
  logic          do_pop;

  assign tos_nxt = tos + PW'(1);
  assign ras_hit = (cnt != '0);
  // Only the unstalled cycle of a call/ret moves the stack, so a held
  // instruction acts exactly once.
  assign do_push = !f_stall && (f_icode == I_CALL);
  assign do_pop  = !f_stall && (f_icode == I_RET) && ras_hit;

  // Stack pointer and occupancy; underflowing ret leaves both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos <= '0;
      cnt <= '0;
    end else if (do_push) begin
      tos <= tos_nxt;
      if (cnt != FULL) cnt <= cnt + 1'b1;
    end else if (do_pop) begin
      tos <= tos - PW'(1);
      cnt <= cnt - 1'b1;
    end
  end

  // Return-address storage; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (do_push) ras[tos_nxt] <= f_valP;
  end
`endif

  // Next-PC select; the counter is read before any same-cycle training.
  always_comb begin
    predPC       = f_valP;
    f_pred_taken = 1'b0;
    case (f_icode)
      I_JXX: begin
        if ((f_ifun == 4'h0) || ctr[1]) begin
          predPC       = f_valC;
          f_pred_taken = 1'b1;
        end
      end
      I_CALL: begin
        predPC       = f_valC;
        f_pred_taken = 1'b1;
      end
      I_RET: begin
`ifdef PC_PREDICT_RAS_EN
        if (ras_hit) begin
          predPC       = ras[tos];
          f_pred_taken = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Upper PC bits do not take part in indexing.
  logic unused_ok;
  assign unused_ok = ^{f_pc[63:IDX_BITS], e_pc[63:IDX_BITS], f_stall, ctr[0]};

endmodule

// File: tb/tb_pc_predict_bht.sv
// tb_pc_predict_bht: scoreboard bench for pc_predict_bht. A reference
// model (counter array + queue-based return stack) produces the expected
// {predPC, taken} for each driven cycle; results are checked on the
// falling edge. Build with or without PC_PREDICT_RAS_EN.
module tb_pc_predict_bht;

  localparam int IDX   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_stall;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] f_pc, f_valC, f_valP;
  logic        e_upd;
  logic [63:0] e_pc;
  logic        e_Cnd;
  logic [63:0] predPC;
  logic        f_pred_taken;

  pc_predict_bht #(.IDX_BITS(IDX), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .f_stall(f_stall), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP),
    .e_upd(e_upd), .e_pc(e_pc), .e_Cnd(e_Cnd), .predPC(predPC),
    .f_pred_taken(f_pred_taken)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  mbht [1<<IDX];
  logic [63:0] mras [$];
  logic [64:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1<<IDX); i++) mbht[i] = 2'b10;
    mras.delete();
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance model, wait edge.
  task automatic step(input logic [3:0] ic, input logic [3:0] ifn,
                      input logic [63:0] pc, input logic [63:0] vc,
                      input logic [63:0] vp, input logic stl,
                      input logic up, input logic [63:0] ep, input logic cd);
    logic [63:0] xpc;
    logic        xtk;
    logic [64:0] e;
    f_icode = ic; f_ifun = ifn; f_pc = pc; f_valC = vc; f_valP = vp;
    f_stall = stl; e_upd = up; e_pc = ep; e_Cnd = cd;
    xpc = vp; xtk = 1'b0;
    if (ic == 4'h7 && (ifn == 4'h0 || mbht[pc[IDX-1:0]] >= 2'b10)) begin
      xpc = vc; xtk = 1'b1;
    end else if (ic == 4'h8) begin
      xpc = vc; xtk = 1'b1;
    end
`ifdef PC_PREDICT_RAS_EN
    else if (ic == 4'h9 && mras.size() > 0) begin
      xpc = mras[$]; xtk = 1'b1;
    end
`endif
    sb_q.push_back({xpc, xtk});
    @(negedge clk);
    e = sb_q.pop_front();
    chk("predPC", predPC, e[64:1]);
    chk("taken", {63'd0, f_pred_taken}, {63'd0, e[0]});
    if (rst_n && up) begin
      if (cd && mbht[ep[IDX-1:0]] != 2'b11) mbht[ep[IDX-1:0]]++;
      else if (!cd && mbht[ep[IDX-1:0]] != 2'b00) mbht[ep[IDX-1:0]]--;
    end
`ifdef PC_PREDICT_RAS_EN
    if (rst_n && !stl && ic == 4'h8) begin
      if (mras.size() == DEPTH) void'(mras.pop_front());
      mras.push_back(vp);
    end else if (rst_n && !stl && ic == 4'h9 && mras.size() > 0) begin
      void'(mras.pop_back());
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] ifn,
                       input logic [63:0] pc, input logic [63:0] vc,
                       input logic [63:0] vp, input logic stl);
    step(ic, ifn, pc, vc, vp, stl, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic train(input logic [63:0] ep, input logic cd);
    step(4'h1, 4'h0, 64'h300, 64'h0, 64'h301, 1'b0, 1'b1, ep, cd);
  endtask

  initial begin
    rst_n = 1'b0; f_stall = 0; f_icode = 0; f_ifun = 0; f_pc = 0;
    f_valC = 0; f_valP = 0; e_upd = 0; e_pc = 0; e_Cnd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold table: weakly taken everywhere.
    fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49, 1'b0);
    fetch(4'h7, 4'h3, 64'h4b, 64'h180, 64'h54, 1'b0);
    fetch(4'h7, 4'h0, 64'h60, 64'h120, 64'h69, 1'b0);
    fetch(4'h3, 4'h0, 64'h70, 64'h999, 64'h7a, 1'b0);

    // Train down to not-taken, then back up to strongly taken.
    train(64'h40, 1'b0);
    train(64'h40, 1'b0);
    fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49, 1'b0);
    fetch(4'h7, 4'h1, 64'h41, 64'h110, 64'h4a, 1'b0);
    repeat (3) train(64'h40, 1'b1);
    fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49, 1'b0);
    train(64'h40, 1'b0);
    fetch(4'h7, 4'h1, 64'h40, 64'h100, 64'h49, 1'b0);
    fetch(4'h7, 4'h2, 64'h50, 64'h140, 64'h59, 1'b0);

    // Same-cycle read and train of one index uses the old counter.
    train(64'h45, 1'b0);
    step(4'h7, 4'h1, 64'h45, 64'h1a0, 64'h4e, 1'b0, 1'b1, 64'h45, 1'b0);
    fetch(4'h7, 4'h1, 64'h45, 64'h1a0, 64'h4e, 1'b0);

    // call then ret.
    fetch(4'h8, 4'h0, 64'h00, 64'h200, 64'h09, 1'b0);
    fetch(4'h9, 4'h0, 64'h200, 64'h0, 64'h201, 1'b0);
    fetch(4'h9, 4'h0, 64'h210, 64'h0, 64'h211, 1'b0);

    // Stalled call held 3 cycles pushes once; stalled ret pops once.
    repeat (3) fetch(4'h8, 4'h0, 64'h20, 64'h400, 64'h30, 1'b1);
    fetch(4'h8, 4'h0, 64'h20, 64'h400, 64'h30, 1'b0);
    repeat (2) fetch(4'h9, 4'h0, 64'h400, 64'h0, 64'h401, 1'b1);
    fetch(4'h9, 4'h0, 64'h400, 64'h0, 64'h401, 1'b0);
    fetch(4'h9, 4'h0, 64'h410, 64'h0, 64'h411, 1'b0);

    // Overflow: DEPTH+1 calls, then DEPTH+1 rets.
    for (int i = 1; i <= DEPTH + 1; i++)
      fetch(4'h8, 4'h0, 64'h500 + 64'(i), 64'h600, 64'(i * 16), 1'b0);
    for (int i = 0; i <= DEPTH; i++)
      fetch(4'h9, 4'h0, 64'h600 + 64'(i), 64'h0, 64'h700 + 64'(i), 1'b0);

    // Train index 0 to 00, load the RAS, then reset asynchronously.
    train(64'h0, 1'b0);
    train(64'h0, 1'b0);
    fetch(4'h7, 4'h1, 64'h0, 64'h800, 64'h9, 1'b0);
    fetch(4'h8, 4'h0, 64'h30, 64'h900, 64'h39, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    fetch(4'h7, 4'h1, 64'h0, 64'h800, 64'h9, 1'b0);
    fetch(4'h9, 4'h0, 64'h900, 64'h0, 64'h901, 1'b0);
    #2 rst_n = 1'b1;
    fetch(4'h7, 4'h1, 64'h10, 64'h800, 64'h19, 1'b0);

    // Random mix with aliasing PCs and concurrent training.
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
           64'($urandom_range(0, 63)), 64'($urandom), 64'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           64'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
